// File: rtl/rvfpm_xif_rob.sv
// Result reorder buffer for an FPU behind a CORE-V-XIF coprocessor interface.
// Tracks issued instructions until both committed and executed, then returns
// results in order (or oldest-ready-first) through a registered result port.
module rvfpm_xif_rob #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned X_ID_WIDTH   = 4,
    parameter int unsigned FLEN         = 32,
    parameter int unsigned OUT_OF_ORDER = 0
) (
    input  logic                   ck,
    input  logic                   rst,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    input  logic [X_ID_WIDTH-1:0]  alloc_id,
    input  logic [4:0]             alloc_rd,
    input  logic                   alloc_we,
    input  logic                   commit_valid,
    input  logic [X_ID_WIDTH-1:0]  commit_id,
    input  logic                   commit_kill,
    input  logic                   wb_valid,
    input  logic [X_ID_WIDTH-1:0]  wb_id,
    input  logic [FLEN-1:0]        wb_data,
    input  logic [4:0]             wb_fflags,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [X_ID_WIDTH-1:0]  result_id,
    output logic [4:0]             result_rd,
    output logic                   result_we,
    output logic [FLEN-1:0]        result_data,
    output logic [4:0]             result_fflags,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [2:0] {
        S_FREE   = 3'd0,
        S_WAIT   = 3'd1,
        S_DONE_U = 3'd2,
        S_CMT    = 3'd3,
        S_READY  = 3'd4
    } ent_st_t;

    ent_st_t               st_q   [DEPTH];
    ent_st_t               st_upd [DEPTH];
    ent_st_t               st_d   [DEPTH];
    logic [X_ID_WIDTH-1:0] id_q   [DEPTH];
    logic [4:0]            rd_q   [DEPTH];
    logic                  we_q   [DEPTH];
    logic [FLEN-1:0]       data_q [DEPTH];
    logic [4:0]            ff_q   [DEPTH];

    logic [PW-1:0]    head_q, tail_q;
    logic [AW-1:0]    head_idx, tail_idx, sel_idx, scan_idx;
    logic [DEPTH-1:0] cmt_hit, wb_hit;
    logic             alloc_fire, sel_valid, load_en;
    logic [FLEN-1:0]  sel_data;
    logic [4:0]       sel_ff;

    assign head_idx    = head_q[AW-1:0];
    assign tail_idx    = tail_q[AW-1:0];
    assign count       = tail_q - head_q;
    assign alloc_ready = (count < PW'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign load_en     = !result_valid || result_ready;

    // Per-entry state after this cycle's alloc, commit and writeback
    always_comb begin
        cmt_hit = '0;
        wb_hit  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cmt_hit[i] = commit_valid && (id_q[i] == commit_id) &&
                         (st_q[i] == S_WAIT || st_q[i] == S_DONE_U);
            wb_hit[i]  = wb_valid && (id_q[i] == wb_id) &&
                         (st_q[i] == S_WAIT || st_q[i] == S_CMT);
            st_upd[i]  = st_q[i];
            case (st_q[i])
                S_WAIT: begin
                    if (cmt_hit[i] && commit_kill)     st_upd[i] = S_FREE;
                    else if (cmt_hit[i] && wb_hit[i])  st_upd[i] = S_READY;
                    else if (cmt_hit[i])               st_upd[i] = S_CMT;
                    else if (wb_hit[i])                st_upd[i] = S_DONE_U;
                end
                S_DONE_U: if (cmt_hit[i]) st_upd[i] = commit_kill ? S_FREE : S_READY;
                S_CMT:    if (wb_hit[i])  st_upd[i] = S_READY;
                default:  ;
            endcase
            // a fresh entry can see a same-cycle commit but never a writeback
            if (alloc_fire && (tail_idx == AW'(i))) begin
                if (commit_valid && (commit_id == alloc_id))
                    st_upd[i] = commit_kill ? S_FREE : S_CMT;
                else
                    st_upd[i] = S_WAIT;
            end
        end
    end

    // Pick the entry to return: head only, or first ready from head
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = head_idx;
        scan_idx  = head_idx;
        if (OUT_OF_ORDER == 0) begin
            sel_valid = (count != '0) && (st_upd[head_idx] == S_READY);
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                scan_idx = head_idx + AW'(k);
                if (!sel_valid && (PW'(k) < count) && (st_upd[scan_idx] == S_READY)) begin
                    sel_valid = 1'b1;
                    sel_idx   = scan_idx;
                end
            end
        end
    end

    // Writeback data bypasses the entry so a completing result leaves next cycle
    assign sel_data = wb_hit[sel_idx] ? wb_data   : data_q[sel_idx];
    assign sel_ff   = wb_hit[sel_idx] ? wb_fflags : ff_q[sel_idx];

    // Final entry state: the entry moved into the output register is released
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) st_d[i] = st_upd[i];
        if (load_en && sel_valid) st_d[sel_idx] = S_FREE;
    end

    // Entry storage
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                st_q[i]   <= S_FREE;
                id_q[i]   <= '0;
                rd_q[i]   <= '0;
                we_q[i]   <= 1'b0;
                data_q[i] <= '0;
                ff_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                st_q[i] <= st_d[i];
                if (wb_hit[i]) begin
                    data_q[i] <= wb_data;
                    ff_q[i]   <= wb_fflags;
                end
            end
            if (alloc_fire) begin
                id_q[tail_idx] <= alloc_id;
                rd_q[tail_idx] <= alloc_rd;
                we_q[tail_idx] <= alloc_we;
            end
        end
    end

    // Head reclaims freed entries in order; tail follows allocation
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if ((head_q != tail_q) && (st_q[head_idx] == S_FREE)) head_q <= head_q + PW'(1);
            if (alloc_fire) tail_q <= tail_q + PW'(1);
        end
    end

    // Registered result channel, held while stalled
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            result_valid  <= 1'b0;
            result_id     <= '0;
            result_rd     <= '0;
            result_we     <= 1'b0;
            result_data   <= '0;
            result_fflags <= '0;
        end else if (load_en) begin
            result_valid <= sel_valid;
            if (sel_valid) begin
                result_id     <= id_q[sel_idx];
                result_rd     <= rd_q[sel_idx];
                result_we     <= we_q[sel_idx];
                result_data   <= sel_data;
                result_fflags <= sel_ff;
            end
        end
    end

endmodule

// File: tb/tb_rvfpm_xif_rob.sv
// Directed bench for rvfpm_xif_rob: an in-order and an out-of-order instance
// share stimulus; each has its own expected-result queue.
module tb_rvfpm_xif_rob;

    typedef struct packed {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic [4:0]  ff;
    } exp_t;

    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_valid = 1'b0, alloc_we = 1'b0;
    logic [3:0]  alloc_id = '0;
    logic [4:0]  alloc_rd = '0;
    logic        commit_valid = 1'b0, commit_kill = 1'b0;
    logic [3:0]  commit_id = '0;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_id = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  wb_fflags = '0;
    logic        result_ready = 1'b1;

    logic        ar0, rv0, rwe0, ar1, rv1, rwe1;
    logic [3:0]  rid0, rid1;
    logic [4:0]  rrd0, rff0, rrd1, rff1;
    logic [31:0] rdat0, rdat1;
    logic [2:0]  cnt0, cnt1;

    int   tests = 0, fails = 0, xfer0 = 0, xfer1 = 0, x0, x1;
    exp_t q0[$], q1[$];
    exp_t obs, expv;

    always #5 ck = ~ck;

    rvfpm_xif_rob #(.DEPTH(4), .X_ID_WIDTH(4), .FLEN(32), .OUT_OF_ORDER(0)) u_ino (
        .ck(ck), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(ar0), .alloc_id(alloc_id),
        .alloc_rd(alloc_rd), .alloc_we(alloc_we),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_fflags(wb_fflags),
        .result_valid(rv0), .result_ready(result_ready), .result_id(rid0),
        .result_rd(rrd0), .result_we(rwe0), .result_data(rdat0), .result_fflags(rff0),
        .count(cnt0)
    );

    rvfpm_xif_rob #(.DEPTH(4), .X_ID_WIDTH(4), .FLEN(32), .OUT_OF_ORDER(1)) u_ooo (
        .ck(ck), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(ar1), .alloc_id(alloc_id),
        .alloc_rd(alloc_rd), .alloc_we(alloc_we),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_fflags(wb_fflags),
        .result_valid(rv1), .result_ready(result_ready), .result_id(rid1),
        .result_rd(rrd1), .result_we(rwe1), .result_data(rdat1), .result_fflags(rff1),
        .count(cnt1)
    );

    function automatic exp_t mk(input logic [3:0] id, input logic [4:0] rd, input logic we,
                                input logic [31:0] data, input logic [4:0] ff);
        return {id, rd, we, data, ff};
    endfunction

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_alloc(input logic [3:0] id, input logic [4:0] rd);
        alloc_valid = 1'b1; alloc_id = id; alloc_rd = rd; alloc_we = 1'b1;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        commit_valid = 1'b1; commit_id = id; commit_kill = kill;
        tick();
        commit_valid = 1'b0; commit_kill = 1'b0;
    endtask

    task automatic do_wb(input logic [3:0] id, input logic [31:0] d, input logic [4:0] ff);
        wb_valid = 1'b1; wb_id = id; wb_data = d; wb_fflags = ff;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic do_cw(input logic [3:0] id, input logic [31:0] d, input logic [4:0] ff);
        commit_valid = 1'b1; commit_id = id; commit_kill = 1'b0;
        wb_valid = 1'b1; wb_id = id; wb_data = d; wb_fflags = ff;
        tick();
        commit_valid = 1'b0; wb_valid = 1'b0;
    endtask

    // Scoreboard: every handshake seen must match the front of the queue
    always @(negedge ck) begin
        if (rst && rv0 && result_ready) begin
            xfer0++;
            tests++;
            assert (q0.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_result_ino: observed id %0h expected none", rid0);
            end
            if (q0.size() != 0) begin
                obs  = {rid0, rrd0, rwe0, rdat0, rff0};
                expv = q0.pop_front();
                chk("result_ino", 64'(obs), 64'(expv));
            end
        end
        if (rst && rv1 && result_ready) begin
            xfer1++;
            tests++;
            assert (q1.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_result_ooo: observed id %0h expected none", rid1);
            end
            if (q1.size() != 0) begin
                obs  = {rid1, rrd1, rwe1, rdat1, rff1};
                expv = q1.pop_front();
                chk("result_ooo", 64'(obs), 64'(expv));
            end
        end
    end

    initial begin
        // reset state
        #3;
        chk("rst_out_ino", 64'({rv0, rid0, rrd0, rwe0, rdat0, rff0}), 64'(0));
        chk("rst_out_ooo", 64'({rv1, rid1, rrd1, rwe1, rdat1, rff1}), 64'(0));
        chk("rst_cnt_ino", 64'({ar0, cnt0}), 64'({1'b1, 3'd0}));
        chk("rst_cnt_ooo", 64'({ar1, cnt1}), 64'({1'b1, 3'd0}));
        #9 rst = 1'b1;
        tick();

        // in-order vs oldest-ready-first return
        result_ready = 1'b1;
        do_alloc(4'd1, 5'd3);
        do_alloc(4'd2, 5'd4);
        do_wb(4'd2, 32'h4000_0000, 5'h00);
        do_wb(4'd1, 32'h3F80_0000, 5'h01);
        q0.push_back(mk(4'd1, 5'd3, 1'b1, 32'h3F80_0000, 5'h01));
        q0.push_back(mk(4'd2, 5'd4, 1'b1, 32'h4000_0000, 5'h00));
        q1.push_back(mk(4'd2, 5'd4, 1'b1, 32'h4000_0000, 5'h00));
        q1.push_back(mk(4'd1, 5'd3, 1'b1, 32'h3F80_0000, 5'h01));
        do_commit(4'd2, 1'b0);
        do_commit(4'd1, 1'b0);
        repeat (4) tick();
        chk("order_drain", 64'({q0.size(), q1.size()}), 64'(0));
        chk("order_cnt", 64'({cnt0, cnt1}), 64'(0));

        // writeback of a committed head entry shows up one cycle later
        do_alloc(4'd5, 5'd7);
        do_commit(4'd5, 1'b0);
        q0.push_back(mk(4'd5, 5'd7, 1'b1, 32'h1234_5678, 5'h02));
        q1.push_back(mk(4'd5, 5'd7, 1'b1, 32'h1234_5678, 5'h02));
        do_wb(4'd5, 32'h1234_5678, 5'h02);
        chk("latency", 64'({rv0, rid0, rv1, rid1}), 64'({1'b1, 4'd5, 1'b1, 4'd5}));
        repeat (3) tick();

        // commit arriving with the allocation applies to the new entry
        alloc_valid = 1'b1; alloc_id = 4'd6; alloc_rd = 5'd9; alloc_we = 1'b0;
        commit_valid = 1'b1; commit_id = 4'd6; commit_kill = 1'b0;
        tick();
        alloc_valid = 1'b0; commit_valid = 1'b0;
        q0.push_back(mk(4'd6, 5'd9, 1'b0, 32'hBF80_0000, 5'h08));
        q1.push_back(mk(4'd6, 5'd9, 1'b0, 32'hBF80_0000, 5'h08));
        do_wb(4'd6, 32'hBF80_0000, 5'h08);
        chk("same_cycle_cmt", 64'({rv0, rv1}), 64'(2'b11));
        repeat (3) tick();

        // killed entry: no result, capacity reclaimed
        do_alloc(4'd3, 5'd1);
        do_commit(4'd3, 1'b1);
        do_wb(4'd3, 32'hDEAD_BEEF, 5'h1F);
        chk("kill_no_result", 64'({rv0, rv1}), 64'(0));
        tick();
        chk("kill_cnt", 64'({cnt0, cnt1}), 64'(0));

        // full buffer, then retire the head
        do_alloc(4'd8, 5'd8);
        do_alloc(4'd9, 5'd9);
        do_alloc(4'd10, 5'd10);
        do_alloc(4'd11, 5'd11);
        chk("full", 64'({ar0, cnt0, ar1, cnt1}), 64'({1'b0, 3'd4, 1'b0, 3'd4}));
        q0.push_back(mk(4'd8, 5'd8, 1'b1, 32'hC000_0000, 5'h04));
        q1.push_back(mk(4'd8, 5'd8, 1'b1, 32'hC000_0000, 5'h04));
        do_cw(4'd8, 32'hC000_0000, 5'h04);
        repeat (2) tick();
        chk("after_retire", 64'({ar0, cnt0, ar1, cnt1}), 64'({1'b1, 3'd3, 1'b1, 3'd3}));

        // backpressure holds the result stable, release gives one transfer
        result_ready = 1'b0;
        q0.push_back(mk(4'd9, 5'd9, 1'b1, 32'h4049_0FDB, 5'h10));
        q1.push_back(mk(4'd9, 5'd9, 1'b1, 32'h4049_0FDB, 5'h10));
        do_cw(4'd9, 32'h4049_0FDB, 5'h10);
        chk("stall_valid", 64'({rv0, rv1}), 64'(2'b11));
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_hold_ino", 64'({rv0, rid0, rdat0, rff0}), 64'({1'b1, 4'd9, 32'h4049_0FDB, 5'h10}));
            chk("stall_hold_ooo", 64'({rv1, rid1, rdat1, rff1}), 64'({1'b1, 4'd9, 32'h4049_0FDB, 5'h10}));
        end
        x0 = xfer0;
        x1 = xfer1;
        result_ready = 1'b1;
        repeat (3) tick();
        chk("one_xfer_ino", 64'(xfer0 - x0), 64'(1));
        chk("one_xfer_ooo", 64'(xfer1 - x1), 64'(1));
        chk("released_idle", 64'({rv0, rv1}), 64'(0));

        // reset mid-operation with a pending result and three live entries
        result_ready = 1'b0;
        do_cw(4'd10, 32'h3F00_0000, 5'h00);
        do_alloc(4'd12, 5'd12);
        do_alloc(4'd13, 5'd13);
        chk("pre_rst", 64'({rv0, cnt0, rv1, cnt1}), 64'({1'b1, 3'd3, 1'b1, 3'd3}));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ino", 64'({rv0, cnt0, ar0, rid0, rdat0, rff0}), 64'({1'b0, 3'd0, 1'b1, 4'd0, 32'd0, 5'd0}));
        chk("mid_rst_ooo", 64'({rv1, cnt1, ar1, rid1, rdat1, rff1}), 64'({1'b0, 3'd0, 1'b1, 4'd0, 32'd0, 5'd0}));
        #2 rst = 1'b1;
        result_ready = 1'b1;
        tick();
        do_wb(4'd11, 32'h4080_0000, 5'h00);
        repeat (2) tick();
        chk("post_rst_wb", 64'({rv0, cnt0, rv1, cnt1}), 64'(0));
        chk("queues_empty", 64'({q0.size(), q1.size()}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
